// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer for a variable-latency data memory.
// Holds the pipeline with stall_o while a load/store waits for its ack, and
// returns load data in the single DONE cycle. An access that gets no ack in
// time is aborted and recorded in a sticky error flag.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wrdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_acc;
  logic                w_timeout;

  assign w_acc     = MemRead_i | MemWrite_i;
  // The abort fires in the TIMEOUT-th REQ cycle (cnt starts at 0 in the first).
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and the combinational stall; stall rises in IDLE so EX/MEM
  // freezes from the first cycle of the access.
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_acc;
        if (w_acc) w_next = S_REQ;
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (mem_ack_i || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter, latched request fields and load result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_addr  <= addr_i;
            r_wdata <= wrdata_i;
            r_we    <= MemWrite_i;   // load+store together is a store
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack_i) begin
            // ack beats a coincident timeout; stores leave rdata untouched
            if (!r_we) r_rdata <= mem_rdata_i;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Request is a pure decode of the state register, so it is glitch-free and
  // cleared by reset along with the state.
  assign mem_req_o   = (r_state == S_REQ);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;

endmodule
